// File: rtl/ifexp_sweeper.sv
// Built-in self-test sweeper for an (A > B) ? A : B+1 select unit: drives every
// operand pair inside a programmable rectangle, checks XIN and records the first failure.
module ifexp_sweeper #(
  parameter int NBITS     = 8,
  parameter int LATENCY   = 1,
  parameter int ECNT_BITS = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [NBITS-1:0]     A_LIMIT,
  input  logic [NBITS-1:0]     B_LIMIT,
  input  logic [NBITS-1:0]     XIN,
  output logic [NBITS-1:0]     A_OUT,
  output logic [NBITS-1:0]     B_OUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [ECNT_BITS-1:0] ERR_COUNT,
  output logic                 FAIL_VALID,
  output logic [NBITS-1:0]     FAIL_A,
  output logic [NBITS-1:0]     FAIL_B,
  output logic [NBITS-1:0]     FAIL_GOT
);

  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LW-1:0] WAIT_LAST = LW'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] a_lim, b_lim;
  logic [LW-1:0]    wait_cnt;
  logic             start_sweep, do_check, last_pair, mismatch;

  function automatic logic [NBITS-1:0] golden(input logic [NBITS-1:0] a,
                                              input logic [NBITS-1:0] b);
    return (a > b) ? a : (b + 1'b1);
  endfunction

  function automatic logic [ECNT_BITS-1:0] sat_inc(input logic [ECNT_BITS-1:0] v);
    return (&v) ? v : (v + 1'b1);
  endfunction

  // Limits are compared with '<' so an all-ones limit ends the sweep instead of wrapping.
  assign last_pair = !(B_OUT < b_lim) && !(A_OUT < a_lim);
  assign mismatch  = (XIN != golden(A_OUT, B_OUT));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_sweep = 1'b0;
    do_check    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_nxt   = S_DRIVE;
          start_sweep = 1'b1;
        end
      end
      S_DRIVE: if (wait_cnt == WAIT_LAST) state_nxt = S_CHECK;
      S_CHECK: begin
        do_check  = 1'b1;
        state_nxt = last_pair ? S_DONE : S_DRIVE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort freezes results and suppresses any check or restart in the same cycle.
    if (ABORT) begin
      state_nxt   = S_IDLE;
      start_sweep = 1'b0;
      do_check    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_lim      <= '0;
      b_lim      <= '0;
      A_OUT      <= '0;
      B_OUT      <= '0;
      wait_cnt   <= '0;
      ERR_COUNT  <= '0;
      FAIL_VALID <= 1'b0;
      FAIL_A     <= '0;
      FAIL_B     <= '0;
      FAIL_GOT   <= '0;
    end else if (start_sweep) begin
      a_lim      <= A_LIMIT;
      b_lim      <= B_LIMIT;
      A_OUT      <= '0;
      B_OUT      <= '0;
      wait_cnt   <= '0;
      ERR_COUNT  <= '0;
      FAIL_VALID <= 1'b0;
      FAIL_A     <= '0;
      FAIL_B     <= '0;
      FAIL_GOT   <= '0;
    end else if (do_check) begin
      wait_cnt <= '0;
      if (mismatch) begin
        ERR_COUNT <= sat_inc(ERR_COUNT);
        if (!FAIL_VALID) begin
          FAIL_VALID <= 1'b1;
          FAIL_A     <= A_OUT;
          FAIL_B     <= B_OUT;
          FAIL_GOT   <= XIN;
        end
      end
      if (B_OUT < b_lim) begin
        B_OUT <= B_OUT + 1'b1;
      end else if (A_OUT < a_lim) begin
        B_OUT <= '0;
        A_OUT <= A_OUT + 1'b1;
      end
    end else if (state == S_DRIVE && wait_cnt != WAIT_LAST) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign BUSY = (state == S_DRIVE) || (state == S_CHECK);
  assign DONE = (state == S_DONE);
  assign PASS = DONE && (ERR_COUNT == '0);

endmodule

// File: tb/tb_ifexp_sweeper.sv
// Directed bench for ifexp_sweeper: a behavioural select unit (correct or faulty)
// answers the sweeper, and sweep timing and results are checked against hand values.
module tb_ifexp_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort;
  logic [7:0] a_limit, b_limit;
  int         mode;
  int         n_vec = 0;
  int         n_err = 0;

  logic [7:0]  d_xin, d_a, d_b, d_fa, d_fb, d_fg;
  logic        d_busy, d_done, d_pass, d_fv;
  logic [15:0] d_err;
  logic [7:0]  s_xin, s_a, s_b, s_fa, s_fb, s_fg;
  logic        s_busy, s_done, s_pass, s_fv;
  logic [3:0]  s_err;
  logic [7:0]  l_xin, l_a, l_b, l_fa, l_fb, l_fg;
  logic        l_busy, l_done, l_pass, l_fv;
  logic [15:0] l_err;

  // mode 0: correct select unit, 1: returns A, 2: stuck at 0xAA
  function automatic logic [7:0] model(input int m, input logic [7:0] a, input logic [7:0] b);
    case (m)
      0:       return (a > b) ? a : 8'(b + 8'd1);
      1:       return a;
      default: return 8'hAA;
    endcase
  endfunction

  always_comb d_xin = model(mode, d_a, d_b);
  always_comb s_xin = model(mode, s_a, s_b);
  always_comb l_xin = model(mode, l_a, l_b);

  ifexp_sweeper u_dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort),
    .A_LIMIT(a_limit), .B_LIMIT(b_limit), .XIN(d_xin),
    .A_OUT(d_a), .B_OUT(d_b), .BUSY(d_busy), .DONE(d_done), .PASS(d_pass),
    .ERR_COUNT(d_err), .FAIL_VALID(d_fv), .FAIL_A(d_fa), .FAIL_B(d_fb), .FAIL_GOT(d_fg)
  );

  ifexp_sweeper #(.ECNT_BITS(4)) u_sat (
    .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort),
    .A_LIMIT(a_limit), .B_LIMIT(b_limit), .XIN(s_xin),
    .A_OUT(s_a), .B_OUT(s_b), .BUSY(s_busy), .DONE(s_done), .PASS(s_pass),
    .ERR_COUNT(s_err), .FAIL_VALID(s_fv), .FAIL_A(s_fa), .FAIL_B(s_fb), .FAIL_GOT(s_fg)
  );

  ifexp_sweeper #(.LATENCY(3)) u_lat (
    .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort),
    .A_LIMIT(a_limit), .B_LIMIT(b_limit), .XIN(l_xin),
    .A_OUT(l_a), .B_OUT(l_b), .BUSY(l_busy), .DONE(l_done), .PASS(l_pass),
    .ERR_COUNT(l_err), .FAIL_VALID(l_fv), .FAIL_A(l_fa), .FAIL_B(l_fb), .FAIL_GOT(l_fg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse START, then count edges until u_dut raises DONE; optionally re-pulse START at edge poke.
  task automatic run_sweep(input int budget, input int poke, output int cyc, output int max_a);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc   = 0;
    max_a = 0;
    while (!d_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (int'(d_a) > max_a) max_a = int'(d_a);
      start = (cyc == poke);
    end
    start = 1'b0;
  endtask

  int cyc, max_a, extra;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    a_limit = 8'd0; b_limit = 8'd0; mode = 0;
    #12;
    check("rst_outputs", {d_a, d_b, d_busy, d_done, d_pass, d_fv}, 0);
    check("rst_err", d_err, 0);
    check("rst_fail", {d_fa, d_fb, d_fg}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Correct model, 3/3: 16 pairs, 32 cycles; LATENCY=3 instance needs 64
    a_limit = 8'd3; b_limit = 8'd3; mode = 0;
    run_sweep(200, -1, cyc, max_a);
    check("ok_cycles", cyc, 32);
    check("ok_err", d_err, 0);
    check("ok_pass", d_pass, 1);
    check("ok_fv", d_fv, 0);
    check("ok_busy", d_busy, 0);
    check("ok_final_ab", {d_a, d_b}, {8'd3, 8'd3});
    extra = 0;
    while (!l_done && extra < 200) begin @(negedge clk); extra++; end
    check("lat_cycles", cyc + extra, 64);
    check("lat_pass", l_pass, 1);

    // Faulty XIN = A_OUT: a<=b pairs fail (10 of them), first at (0,0)
    mode = 1;
    run_sweep(200, -1, cyc, max_a);
    check("fa_cycles", cyc, 32);
    check("fa_err", d_err, 10);
    check("fa_pass", d_pass, 0);
    check("fa_done", d_done, 1);
    check("fa_fv", d_fv, 1);
    check("fa_capture", {d_fa, d_fb, d_fg}, 0);

    // Wrap boundary: B limit 255, pair (0,255) expects 0
    mode = 0; a_limit = 8'd0; b_limit = 8'd255;
    run_sweep(2000, -1, cyc, max_a);
    check("wr_cycles", cyc, 512);
    check("wr_max_a", max_a, 0);
    check("wr_err", d_err, 0);
    check("wr_pass", d_pass, 1);
    check("wr_final_b", d_b, 255);

    // Stuck at 0xAA, 7/7: 64 failures, 4-bit counter saturates at 15
    mode = 2; a_limit = 8'd7; b_limit = 8'd7;
    run_sweep(400, -1, cyc, max_a);
    check("sat_cycles", cyc, 128);
    check("sat_err4", s_err, 15);
    check("sat_err16", d_err, 64);
    check("sat_capture", {s_fa, s_fb, s_fg}, {8'd0, 8'd0, 8'hAA});
    check("sat_pass", s_pass, 0);

    // Abort with ABORT sampled at edge 10: four failing checks already counted
    mode = 1; a_limit = 8'd3; b_limit = 8'd3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("ab_busy", d_busy, 0);
    check("ab_done", d_done, 0);
    check("ab_err", d_err, 4);
    check("ab_fv", d_fv, 1);
    @(negedge clk);
    check("ab_idle_hold", {d_busy, d_done}, 0);
    mode = 0;
    run_sweep(200, -1, cyc, max_a);
    check("ab_re_cycles", cyc, 32);
    check("ab_re_err", d_err, 0);
    check("ab_re_pass", d_pass, 1);
    check("ab_re_fv", d_fv, 0);

    // Restart from DONE with new limits 1/2; a START while busy at edge 3 is ignored
    a_limit = 8'd1; b_limit = 8'd2;
    run_sweep(200, 3, cyc, max_a);
    check("rs_cycles", cyc, 12);
    check("rs_final_ab", {d_a, d_b}, {8'd1, 8'd2});
    check("rs_pass", d_pass, 1);

    // Asynchronous reset mid-sweep with failures already counted
    mode = 1; a_limit = 8'd3; b_limit = 8'd3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_err", d_err, 2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_outputs", {d_a, d_b, d_busy, d_done, d_pass, d_fv}, 0);
    check("ar_err", d_err, 0);
    check("ar_fail", {d_fa, d_fb, d_fg}, 0);
    @(negedge clk); rst_n = 1'b1;
    mode = 0;
    run_sweep(200, -1, cyc, max_a);
    check("ar_re_cycles", cyc, 32);
    check("ar_re_pass", d_pass, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
